// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, prefetches from a combinational
// instruction memory into a small FIFO and hands {pc, instr} to decode.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_instr,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  input  logic                       halt,
  output logic                       if_valid,
  output logic [31:0]                if_pc,
  output logic [31:0]                if_instr,
  input  logic                       if_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [1:0]                 state_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state;
  logic [31:0]     fetch_pc;
  logic [31:0]     pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic pop;
  logic push;
  logic redirect_en;
  logic unused_lo;

  assign unused_lo   = ^redirect_pc[1:0];
  assign imem_addr   = fetch_pc;
  assign if_valid    = (count != '0);
  assign if_pc       = pc_mem[rd_ptr];
  assign if_instr    = instr_mem[rd_ptr];
  assign fifo_count  = count;
  assign state_o     = state;

  assign pop         = if_valid & if_ready;
  assign redirect_en = redirect_valid & (state != BOOT);
  assign push        = (state == RUN) & ~halt & ~redirect_valid &
                       ((count < CW'(DEPTH)) | pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      case (state)
        BOOT:    state <= RUN;
        RUN:     state <= halt ? HALT : RUN;
        HALT:    state <= halt ? HALT : RUN;
        default: state <= BOOT;
      endcase

      if (redirect_en) begin
        // Flush by collapsing the tail onto the head so the head storage keeps
        // showing the last presented entry while the FIFO is empty.
        wr_ptr   <= rd_ptr;
        count    <= '0;
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else begin
        if (push) begin
          pc_mem[wr_ptr]    <= fetch_pc;
          instr_mem[wr_ptr] <= imem_instr;
          wr_ptr            <= wr_ptr + PW'(1);
          fetch_pc          <= fetch_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: stimulus queues expected deliveries, a
// negedge monitor pops and compares every decode handshake.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic [1:0]  fifo_count;
  logic [1:0]  state_o;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
    .fifo_count(fifo_count), .state_o(state_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0080_0513;
      32'h4:   return 32'h0095_0593;
      32'h8:   return 32'h40a5_8633;
      default: return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  assign imem_instr = mem_word(imem_addr);

  task automatic expect_fetch(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Scoreboard monitor: one comparison per accepted handshake.
  always @(negedge clk) begin
    if (!reset && if_valid && if_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL deliver: unexpected pc=%h instr=%h at %0t", if_pc, if_instr, $time);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({if_pc, if_instr} !== e) begin
          fails++;
          $display("FAIL deliver: got pc=%h instr=%h expected pc=%h instr=%h at %0t",
                   if_pc, if_instr, e[63:32], e[31:0], $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; if_ready = 1'b1;

    // Reset release, streaming with decode always ready
    expect_fetch(32'h0); expect_fetch(32'h4); expect_fetch(32'h8);
    do_reset();
    check("boot_state", 32'(state_o), 32'd0);
    check("boot_valid", 32'(if_valid), 32'd0);
    check("boot_count", 32'(fifo_count), 32'd0);
    check("boot_addr", imem_addr, 32'h0);
    check("boot_if_pc", if_pc, 32'h0);
    check("boot_if_instr", if_instr, 32'h0);
    step();
    check("run_state", 32'(state_o), 32'd1);
    check("c2_valid", 32'(if_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stream_valid", 32'(if_valid), 32'd1);
      check("stream_count", 32'(fifo_count), 32'd1);
    end
    step();
    if_ready = 1'b0;

    // Backpressure: FIFO saturates, PC stalls, head stable
    do_reset();
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      check("bp_count", 32'(fifo_count), 32'd2);
      check("bp_addr", imem_addr, 32'h8);
      check("bp_head_pc", if_pc, 32'h0);
      check("bp_head_instr", if_instr, 32'h0080_0513);
      step();
    end
    expect_fetch(32'h0); expect_fetch(32'h4); expect_fetch(32'h8);
    if_ready = 1'b1;
    repeat (3) step();
    if_ready = 1'b0;
    check("full_again", 32'(fifo_count), 32'd2);

    // Misaligned redirect while full
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0006;
    step();
    redirect_valid = 1'b0;
    check("flush_valid", 32'(if_valid), 32'd0);
    check("flush_count", 32'(fifo_count), 32'd0);
    check("flush_addr", imem_addr, 32'h4);
    step();
    check("redir_pc", if_pc, 32'h4);
    check("redir_valid", 32'(if_valid), 32'd1);

    // Tight loop: redirect to 0x0C, four deliveries per iteration
    for (int it = 0; it < 3; it++) begin
      redirect_valid = 1'b1; redirect_pc = 32'h0000_000C;
      if_ready = (it != 0);
      expect_fetch(32'h0C); expect_fetch(32'h10); expect_fetch(32'h14); expect_fetch(32'h18);
      step();
      redirect_valid = 1'b0;
      if_ready = 1'b1;
      check("loop_empty", 32'(fifo_count), 32'd0);
      repeat (4) step();
    end

    // Halt with two entries buffered
    if_ready = 1'b0;
    expect_fetch(32'h1C); expect_fetch(32'h20);
    step();
    halt = 1'b1; if_ready = 1'b1;
    check("halt_count2", 32'(fifo_count), 32'd2);
    step();
    check("halt_state", 32'(state_o), 32'd2);
    check("halt_addr", imem_addr, 32'h20);
    step();
    check("halt_drained", 32'(fifo_count), 32'd0);
    check("halt_valid", 32'(if_valid), 32'd0);
    check("halt_addr2", imem_addr, 32'h20);
    step();
    halt = 1'b0;
    check("halt_hold", 32'(state_o), 32'd2);
    step();
    check("resume_state", 32'(state_o), 32'd1);
    check("resume_count", 32'(fifo_count), 32'd0);
    step();
    check("resume_head", if_pc, 32'h20);

    // Wrap-around at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    expect_fetch(32'hFFFF_FFFC); expect_fetch(32'h0);
    step();
    redirect_valid = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_next", imem_addr, 32'h0);
    step();
    step();
    if_ready = 1'b0;
    check("pre_reset_count", 32'(fifo_count), 32'd1);

    // Reset mid-operation with a concurrent redirect
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    step();
    reset = 1'b0; redirect_valid = 1'b0;
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_state", 32'(state_o), 32'd0);

    step();
    step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
